icache_fetch_responder: RTL and testbench

//  Responder side of the fetch-address interface: accepts the physical I-cache read address driven by the

---
 rtl/icache_fetch_responder.sv | 177 +++++++++++++++++
 tb/tb_icache_fetch_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache answering fetch reads one cycle after the address is sampled.
// Misses issue a whole-line fill to memory; a flush sequencer clears one valid bit per cycle.
module icache_fetch_responder #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned FETCH_WIDTH = 2,
   parameter int unsigned INSN_BYTES  = 4,
   parameter int unsigned LINE_BYTES  = 16,
   parameter int unsigned NUM_SETS    = 64
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                readEnable,
   input  logic [ADDR_WIDTH-1:0]               readAddrIn,
   output logic                                readHit,
   output logic [FETCH_WIDTH-1:0]              readValid,
   output logic [FETCH_WIDTH*INSN_BYTES*8-1:0] readData,
   output logic                                stallReq,
   input  logic                                flushReq,
   output logic                                memReadReq,
   output logic [ADDR_WIDTH-1:0]               memReadAddr,
   input  logic                                memReadAck,
   input  logic                                memReadDataValid,
   input  logic [LINE_BYTES*8-1:0]             memReadData
);

   localparam int unsigned OFF    = $clog2(LINE_BYTES);
   localparam int unsigned IDX    = $clog2(NUM_SETS);
   localparam int unsigned TAG_W  = ADDR_WIDTH - OFF - IDX;
   localparam int unsigned IB     = $clog2(INSN_BYTES);
   localparam int unsigned WORD_W = INSN_BYTES * 8;
   localparam int unsigned WORDS  = LINE_BYTES / INSN_BYTES;
   localparam int unsigned WIDX   = $clog2(WORDS);
   localparam int unsigned LINE_W = LINE_BYTES * 8;
   localparam int unsigned DATA_W = FETCH_WIDTH * WORD_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_FLUSH
   } state_e;

   state_e                  state_q;
   logic [NUM_SETS-1:0]     valid_q;
   logic [TAG_W-1:0]        tag_q  [NUM_SETS];
   logic [LINE_W-1:0]       data_q [NUM_SETS];
   logic [IDX-1:0]          flush_cnt_q;
   logic                    flush_pend_q;
   logic                    miss_q;
   logic [ADDR_WIDTH-1:0]   fill_addr_q;
   logic                    mem_req_q;
   logic                    rd_hit_q;
   logic [FETCH_WIDTH-1:0]  rd_valid_q;
   logic [DATA_W-1:0]       rd_data_q;

   logic [IDX-1:0]          rd_idx;
   logic [TAG_W-1:0]        rd_tag;
   logic [WIDX-1:0]         rd_word;
   logic [IDX-1:0]          fill_idx;
   logic                    lookup_hit;
   logic [FETCH_WIDTH-1:0]  lookup_valid;
   logic [DATA_W-1:0]       lookup_data;
   logic [WORD_W-1:0]       line_words [WORDS];
   logic [WIDX:0]           slot;
   logic                    unused_addr_bits;

   assign rd_idx           = readAddrIn[OFF +: IDX];
   assign rd_tag           = readAddrIn[ADDR_WIDTH-1 -: TAG_W];
   assign rd_word          = readAddrIn[IB +: WIDX];
   assign fill_idx         = fill_addr_q[OFF +: IDX];
   assign unused_addr_bits = ^readAddrIn[IB-1:0];

   // Tag compare and slot extraction; slots past the end of the line stay invalid and zero.
   always_comb begin
      lookup_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
      lookup_valid = '0;
      lookup_data  = '0;
      slot         = '0;
      for (int unsigned w = 0; w < WORDS; w++) begin
         line_words[w] = data_q[rd_idx][w*WORD_W +: WORD_W];
      end
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         slot = {1'b0, rd_word} + (WIDX+1)'(i);
         if (!slot[WIDX]) begin
            lookup_valid[i]                 = 1'b1;
            lookup_data[i*WORD_W +: WORD_W] = line_words[slot[WIDX-1:0]];
         end
      end
   end

   // Line storage needs no reset: a line is only visible through its valid bit.
   always_ff @(posedge clk) begin
      if (state_q == S_WAIT && memReadDataValid) begin
         data_q[fill_idx] <= memReadData;
         tag_q[fill_idx]  <= fill_addr_q[ADDR_WIDTH-1 -: TAG_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         flush_cnt_q  <= '0;
         flush_pend_q <= 1'b0;
         miss_q       <= 1'b0;
         fill_addr_q  <= '0;
         mem_req_q    <= 1'b0;
         rd_hit_q     <= 1'b0;
         rd_valid_q   <= '0;
         rd_data_q    <= '0;
      end else begin
         rd_hit_q   <= 1'b0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
         miss_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // A miss reported this cycle outranks a simultaneous flush.
               if (miss_q) begin
                  state_q   <= S_REQ;
                  mem_req_q <= 1'b1;
                  if (flushReq) flush_pend_q <= 1'b1;
               end else if (flushReq) begin
                  state_q     <= S_FLUSH;
                  flush_cnt_q <= '0;
               end else if (readEnable) begin
                  rd_hit_q   <= lookup_hit;
                  rd_valid_q <= lookup_hit ? lookup_valid : '0;
                  rd_data_q  <= lookup_hit ? lookup_data : '0;
                  if (!lookup_hit) begin
                     miss_q      <= 1'b1;
                     fill_addr_q <= {readAddrIn[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                  end
               end
            end
            S_REQ: begin
               if (flushReq) flush_pend_q <= 1'b1;
               if (memReadAck) begin
                  state_q   <= S_WAIT;
                  mem_req_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (flushReq) flush_pend_q <= 1'b1;
               if (memReadDataValid) begin
                  valid_q[fill_idx] <= 1'b1;
                  state_q           <= S_DONE;
               end
            end
            S_DONE: begin
               if (flush_pend_q || flushReq) begin
                  state_q      <= S_FLUSH;
                  flush_cnt_q  <= '0;
                  flush_pend_q <= 1'b0;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_FLUSH: begin
               valid_q[flush_cnt_q] <= 1'b0;
               flush_cnt_q          <= flush_cnt_q + IDX'(1);
               if (flush_cnt_q == IDX'(NUM_SETS - 1)) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign readHit     = rd_hit_q;
   assign readValid   = rd_valid_q;
   assign readData    = rd_data_q;
   assign memReadReq  = mem_req_q;
   assign memReadAddr = fill_addr_q;
   assign stallReq    = miss_q || (state_q != S_IDLE);

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Bench for icache_fetch_responder: directed vector table, multi-cycle corner sequences and
// randomized reads/flushes checked against a line-level cache model.
module tb_icache_fetch_responder;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          readEnable = 1'b0;
   logic [31:0]   readAddrIn = '0;
   logic          readHit;
   logic [1:0]    readValid;
   logic [63:0]   readData;
   logic          stallReq;
   logic          flushReq = 1'b0;
   logic          memReadReq;
   logic [31:0]   memReadAddr;
   logic          memReadAck = 1'b0;
   logic          memReadDataValid = 1'b0;
   logic [127:0]  memReadData = '0;

   int checks   = 0;
   int failures = 0;

   logic          m_valid [4];
   logic [25:0]   m_tag   [4];

   typedef struct {
      logic        en;
      logic [31:0] addr;
      logic        hit;
      logic [1:0]  vld;
      logic [63:0] data;
   } vec_t;

   vec_t tbl [7];

   icache_fetch_responder #(
      .ADDR_WIDTH (32),
      .FETCH_WIDTH(2),
      .INSN_BYTES (4),
      .LINE_BYTES (16),
      .NUM_SETS   (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .readEnable      (readEnable),
      .readAddrIn      (readAddrIn),
      .readHit         (readHit),
      .readValid       (readValid),
      .readData        (readData),
      .stallReq        (stallReq),
      .flushReq        (flushReq),
      .memReadReq      (memReadReq),
      .memReadAddr     (memReadAddr),
      .memReadAck      (memReadAck),
      .memReadDataValid(memReadDataValid),
      .memReadData     (memReadData)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction

   function automatic logic [127:0] line_bits(input logic [31:0] line);
      logic [127:0] r;
      for (int w = 0; w < 4; w++) r[w*32 +: 32] = mem_word(line + 32'(4*w));
      return r;
   endfunction

   function automatic void model_read(input logic [31:0] a, output logic h,
                                      output logic [1:0] v, output logic [63:0] d);
      int idx;
      int wi;
      idx = int'(a[5:4]);
      wi  = int'(a[3:2]);
      h   = m_valid[idx] && (m_tag[idx] == a[31:6]);
      v   = '0;
      d   = '0;
      if (h) begin
         for (int i = 0; i < 2; i++) begin
            if (wi + i < 4) begin
               v[i]         = 1'b1;
               d[i*32 +: 32] = mem_word({a[31:4], 4'h0} + 32'(4*(wi + i)));
            end
         end
      end
   endfunction

   function automatic void model_fill(input logic [31:0] line);
      m_valid[int'(line[5:4])] = 1'b1;
      m_tag[int'(line[5:4])]   = line[31:6];
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic en, input logic [31:0] addr, input logic eh,
                          input logic [1:0] ev, input logic [63:0] ed, input logic estall,
                          input string nm);
      readEnable = en;
      readAddrIn = addr;
      step();
      readEnable = 1'b0;
      chk({nm, "_hit"}, readHit, eh);
      chk({nm, "_valid"}, readValid, ev);
      chk({nm, "_data"}, readData, ed);
      chk({nm, "_stall"}, stallReq, estall);
   endtask

   // Called in the miss-response cycle; returns in the cycle after DONE.
   task automatic service_miss(input logic [31:0] line, input int ack_wait, input int dv_wait,
                               input logic fl);
      int n;
      n = 0;
      step();
      while (!memReadReq && n < 16) begin
         step();
         n++;
      end
      chk("req_up", memReadReq, 1'b1);
      chk("req_addr", memReadAddr, line);
      readEnable = 1'b1;
      readAddrIn = line;
      for (int k = 0; k < ack_wait; k++) begin
         if (fl && k == 0) flushReq = 1'b1;
         step();
         flushReq = 1'b0;
         chk("req_hold", memReadReq, 1'b1);
         chk("req_addr_hold", memReadAddr, line);
         chk("req_stall", stallReq, 1'b1);
         chk("req_read_ignored", readHit, 1'b0);
      end
      readEnable = 1'b0;
      memReadAck = 1'b1;
      step();
      memReadAck = 1'b0;
      chk("req_drop", memReadReq, 1'b0);
      for (int k = 0; k < dv_wait; k++) begin
         step();
         chk("wait_stall", stallReq, 1'b1);
      end
      memReadData      = line_bits(line);
      memReadDataValid = 1'b1;
      step();
      memReadDataValid = 1'b0;
      chk("done_stall", stallReq, 1'b1);
      step();
   endtask

   // Called in the first FLUSH cycle.
   task automatic flush_tail();
      for (int k = 0; k < 4; k++) begin
         chk("flush_stall", stallReq, 1'b1);
         step();
      end
      chk("flush_end", stallReq, 1'b0);
      model_clear();
   endtask

   task automatic do_flush();
      flushReq = 1'b1;
      step();
      flushReq = 1'b0;
      flush_tail();
   endtask

   task automatic read_auto(input logic [31:0] a, input string nm);
      logic        h;
      logic [1:0]  v;
      logic [63:0] d;
      model_read(a, h, v, d);
      do_read(1'b1, a, h, v, d, !h, nm);
      if (!h) begin
         service_miss({a[31:4], 4'h0}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
         chk({nm, "_idle_after_fill"}, stallReq, 1'b0);
         model_fill({a[31:4], 4'h0});
         model_read(a, h, v, d);
         do_read(1'b1, a, h, v, d, 1'b0, {nm, "_refetch"});
      end
   endtask

   initial begin
      logic [31:0] w0, w1, w2, w3;
      logic [31:0] ra;
      int          r;
      model_clear();
      for (int i = 0; i < 4; i++) m_tag[i] = '0;

      // Reset state
      step();
      step();
      chk("rst_hit", readHit, 1'b0);
      chk("rst_valid", readValid, 2'b00);
      chk("rst_data", readData, 64'h0);
      chk("rst_stall", stallReq, 1'b0);
      chk("rst_req", memReadReq, 1'b0);
      chk("rst_addr", memReadAddr, 32'h0);
      rst = 1'b0;
      step();

      // Cold miss on line 0x100
      do_read(1'b1, 32'h100, 1'b0, 2'b00, 64'h0, 1'b1, "cold");
      service_miss(32'h100, 0, 0, 1'b0);
      chk("cold_idle", stallReq, 1'b0);
      model_fill(32'h100);

      // Directed hit vectors within the filled line
      w0 = mem_word(32'h100);
      w1 = mem_word(32'h104);
      w2 = mem_word(32'h108);
      w3 = mem_word(32'h10C);
      tbl[0] = '{1'b1, 32'h100, 1'b1, 2'b11, {w1, w0}};
      tbl[1] = '{1'b1, 32'h104, 1'b1, 2'b11, {w2, w1}};
      tbl[2] = '{1'b1, 32'h108, 1'b1, 2'b11, {w3, w2}};
      tbl[3] = '{1'b1, 32'h10C, 1'b1, 2'b01, {32'h0, w3}};
      tbl[4] = '{1'b1, 32'h10E, 1'b1, 2'b01, {32'h0, w3}};
      tbl[5] = '{1'b0, 32'h100, 1'b0, 2'b00, 64'h0};
      tbl[6] = '{1'b1, 32'h101, 1'b1, 2'b11, {w1, w0}};
      for (int i = 0; i < 7; i++) begin
         do_read(tbl[i].en, tbl[i].addr, tbl[i].hit, tbl[i].vld, tbl[i].data, 1'b0,
                 $sformatf("vec%0d", i));
      end

      // Conflict on index 0
      read_auto(32'h140, "conflict_new");
      read_auto(32'h100, "conflict_old");

      // Flush then the line must miss
      do_flush();
      read_auto(32'h100, "post_flush");

      // Backpressured fill with a flush recorded during REQ
      do_flush();
      do_read(1'b1, 32'h100, 1'b0, 2'b00, 64'h0, 1'b1, "bp");
      service_miss(32'h100, 5, 1, 1'b1);
      flush_tail();
      read_auto(32'h100, "bp_after");

      // Reset while waiting for fill data
      do_flush();
      do_read(1'b1, 32'h100, 1'b0, 2'b00, 64'h0, 1'b1, "rstwait");
      step();
      chk("rstwait_req", memReadReq, 1'b1);
      memReadAck = 1'b1;
      step();
      memReadAck = 1'b0;
      chk("rstwait_in_wait", stallReq, 1'b1);
      rst = 1'b1;
      #1;
      chk("rstwait_req_drop", memReadReq, 1'b0);
      chk("rstwait_stall_drop", stallReq, 1'b0);
      step();
      rst = 1'b0;
      model_clear();
      memReadData      = line_bits(32'h100);
      memReadDataValid = 1'b1;
      step();
      memReadDataValid = 1'b0;
      chk("late_data_ignored", stallReq, 1'b0);
      read_auto(32'h100, "rstwait_after");

      // Randomized reads and flushes against the model
      for (int it = 0; it < 200; it++) begin
         r  = int'($urandom_range(0, 9));
         ra = (32'($urandom_range(4, 6)) << 6) | (32'($urandom_range(0, 3)) << 4) |
              32'($urandom_range(0, 15));
         if (r == 0) begin
            do_flush();
         end else if (r == 1) begin
            do_read(1'b0, ra, 1'b0, 2'b00, 64'h0, 1'b0, "rnd_idle");
         end else begin
            read_auto(ra, "rnd");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
